multi_retire_fsm: RTL and testbench

- Parametrised successor to the single-lane uop-to-ingress FSM of the CVA6 trace-encoder connector.
- Accepts up to NRET retired instructions per cycle and compresses runs of sequential instructions into E-trace blocks.
- A block is closed by a discontinuity, counter saturation or flush. The block emits one ingress packet per closing lane, registered, towards the trace encoder.

---
 rtl/multi_retire_fsm.sv | 185 ++++++++++++++++++
 tb/tb_multi_retire_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_retire_fsm.sv
// Multi-lane retire-to-ingress FSM: compresses runs of sequential retired
// instructions into E-trace blocks and emits one registered packet per closing lane.
module multi_retire_fsm #(
    parameter int NRET        = 2,
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 32,
    parameter int ITYPE_LEN   = 3,
    parameter int PRIV_LEN    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NRET-1:0]               valid_i,
    input  logic [NRET*XLEN-1:0]          iaddr_i,
    input  logic [NRET-1:0]               compressed_i,
    input  logic [NRET*ITYPE_LEN-1:0]     itype_i,
    input  logic [XLEN-1:0]               cause_i,
    input  logic [XLEN-1:0]               tval_i,
    input  logic [PRIV_LEN-1:0]           priv_i,
    input  logic                          flush_i,
    output logic [NRET-1:0]               valid_o,
    output logic [NRET*IRETIRE_LEN-1:0]   iretire_o,
    output logic [NRET-1:0]               ilastsize_o,
    output logic [NRET*ITYPE_LEN-1:0]     itype_o,
    output logic [NRET*XLEN-1:0]          cause_o,
    output logic [NRET*XLEN-1:0]          tval_o,
    output logic [NRET*PRIV_LEN-1:0]      priv_o,
    output logic [NRET*XLEN-1:0]          iaddr_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    // Close threshold 2^IRETIRE_LEN-3 keeps the count clear of overflow.
    localparam logic [IRETIRE_LEN-1:0] SAT = {IRETIRE_LEN{1'b1}} - IRETIRE_LEN'(2);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [XLEN-1:0]             r_start;
    logic [XLEN-1:0]             w_start_nxt;
    logic [IRETIRE_LEN-1:0]      r_cnt;
    logic [IRETIRE_LEN-1:0]      w_cnt_nxt;
    logic                        r_lsize;
    logic                        w_lsize_nxt;

    logic                        w_open;
    logic                        w_close;
    logic [ITYPE_LEN-1:0]        w_ity;
    logic [NRET-1:0]             w_last;

    logic [NRET-1:0]             w_valid_nxt;
    logic [NRET*IRETIRE_LEN-1:0] w_iretire_nxt;
    logic [NRET-1:0]             w_ilastsize_nxt;
    logic [NRET*ITYPE_LEN-1:0]   w_itype_nxt;
    logic [NRET*XLEN-1:0]        w_cause_nxt;
    logic [NRET*XLEN-1:0]        w_tval_nxt;
    logic [NRET*PRIV_LEN-1:0]    w_priv_nxt;
    logic [NRET*XLEN-1:0]        w_iaddr_nxt;

    // One-hot marker of the highest valid lane (valid lanes are contiguous).
    always_comb begin
        w_last = {NRET{1'b0}};
        for (int k = 0; k < NRET; k++) begin
            if (valid_i[k]) begin
                w_last    = {NRET{1'b0}};
                w_last[k] = 1'b1;
            end else begin
                w_last = w_last;
            end
        end
    end

    // Lane chain: accumulate lanes in ascending order, build packets and next state.
    always_comb begin
        w_open          = (r_state == ST_OPEN);
        w_start_nxt     = r_start;
        w_cnt_nxt       = r_cnt;
        w_lsize_nxt     = r_lsize;
        w_close         = 1'b0;
        w_ity           = {ITYPE_LEN{1'b0}};
        w_valid_nxt     = '0;
        w_iretire_nxt   = '0;
        w_ilastsize_nxt = '0;
        w_itype_nxt     = '0;
        w_cause_nxt     = '0;
        w_tval_nxt      = '0;
        w_priv_nxt      = '0;
        w_iaddr_nxt     = '0;

        for (int k = 0; k < NRET; k++) begin
            w_ity = itype_i[k*ITYPE_LEN +: ITYPE_LEN];
            if (valid_i[k]) begin
                if (!w_open) begin
                    w_start_nxt = iaddr_i[k*XLEN +: XLEN];
                    w_cnt_nxt   = {IRETIRE_LEN{1'b0}};
                end else begin
                    w_start_nxt = w_start_nxt;
                end
                w_cnt_nxt   = w_cnt_nxt + (compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
                w_lsize_nxt = ~compressed_i[k];
                w_close     = (w_ity != {ITYPE_LEN{1'b0}}) || (w_cnt_nxt >= SAT)
                              || (flush_i && w_last[k]);
                if (w_close) begin
                    w_valid_nxt[k]                                = 1'b1;
                    w_iretire_nxt[k*IRETIRE_LEN +: IRETIRE_LEN]   = w_cnt_nxt;
                    w_ilastsize_nxt[k]                            = ~compressed_i[k];
                    w_itype_nxt[k*ITYPE_LEN +: ITYPE_LEN]         = w_ity;
                    w_priv_nxt[k*PRIV_LEN +: PRIV_LEN]            = priv_i;
                    w_iaddr_nxt[k*XLEN +: XLEN]                   = w_start_nxt;
                    if ((w_ity == ITYPE_LEN'(1)) || (w_ity == ITYPE_LEN'(2))) begin
                        w_cause_nxt[k*XLEN +: XLEN] = cause_i;
                        w_tval_nxt[k*XLEN +: XLEN]  = tval_i;
                    end else begin
                        w_cause_nxt[k*XLEN +: XLEN] = {XLEN{1'b0}};
                        w_tval_nxt[k*XLEN +: XLEN]  = {XLEN{1'b0}};
                    end
                    w_open      = 1'b0;
                    w_start_nxt = {XLEN{1'b0}};
                    w_cnt_nxt   = {IRETIRE_LEN{1'b0}};
                end else begin
                    w_open = 1'b1;
                end
            end else begin
                w_close = 1'b0;
            end
        end

        // A flush on an empty cycle closes the held block on slot 0 from the accumulator.
        if (flush_i && (valid_i == {NRET{1'b0}}) && w_open) begin
            w_valid_nxt[0]                       = 1'b1;
            w_iretire_nxt[IRETIRE_LEN-1:0]       = r_cnt;
            w_ilastsize_nxt[0]                   = r_lsize;
            w_itype_nxt[ITYPE_LEN-1:0]           = {ITYPE_LEN{1'b0}};
            w_priv_nxt[PRIV_LEN-1:0]             = priv_i;
            w_iaddr_nxt[XLEN-1:0]                = r_start;
            w_open                               = 1'b0;
            w_start_nxt                          = {XLEN{1'b0}};
            w_cnt_nxt                            = {IRETIRE_LEN{1'b0}};
        end else begin
            w_open = w_open;
        end

        w_state_nxt = w_open ? ST_OPEN : ST_IDLE;
    end

    // State and accumulator registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_start <= {XLEN{1'b0}};
            r_cnt   <= {IRETIRE_LEN{1'b0}};
            r_lsize <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lsize <= w_lsize_nxt;
        end
    end

    // Registered ingress packet outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= '0;
            iretire_o   <= '0;
            ilastsize_o <= '0;
            itype_o     <= '0;
            cause_o     <= '0;
            tval_o      <= '0;
            priv_o      <= '0;
            iaddr_o     <= '0;
        end else begin
            valid_o     <= w_valid_nxt;
            iretire_o   <= w_iretire_nxt;
            ilastsize_o <= w_ilastsize_nxt;
            itype_o     <= w_itype_nxt;
            cause_o     <= w_cause_nxt;
            tval_o      <= w_tval_nxt;
            priv_o      <= w_priv_nxt;
            iaddr_o     <= w_iaddr_nxt;
        end
    end

endmodule

// File: tb/tb_multi_retire_fsm.sv
// Bench for multi_retire_fsm: directed scenarios plus randomized traffic checked
// against a block-level reference model.
module tb_multi_retire_fsm;

    localparam int NRET = 2;
    localparam int XLEN = 32;
    localparam int IL   = 4;
    localparam int TL   = 3;
    localparam int PL   = 2;
    localparam int SATV = (1 << IL) - 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NRET-1:0]      valid_i = '0;
    logic [NRET*XLEN-1:0] iaddr_i = '0;
    logic [NRET-1:0]      compressed_i = '0;
    logic [NRET*TL-1:0]   itype_i = '0;
    logic [XLEN-1:0]      cause_i = '0;
    logic [XLEN-1:0]      tval_i = '0;
    logic [PL-1:0]        priv_i = '0;
    logic                 flush_i = 1'b0;
    logic [NRET-1:0]      valid_o;
    logic [NRET*IL-1:0]   iretire_o;
    logic [NRET-1:0]      ilastsize_o;
    logic [NRET*TL-1:0]   itype_o;
    logic [NRET*XLEN-1:0] cause_o;
    logic [NRET*XLEN-1:0] tval_o;
    logic [NRET*PL-1:0]   priv_o;
    logic [NRET*XLEN-1:0] iaddr_o;

    multi_retire_fsm #(.NRET(NRET), .XLEN(XLEN), .IRETIRE_LEN(IL), .ITYPE_LEN(TL), .PRIV_LEN(PL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .iaddr_i(iaddr_i),
        .compressed_i(compressed_i), .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i),
        .priv_i(priv_i), .flush_i(flush_i), .valid_o(valid_o), .iretire_o(iretire_o),
        .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o),
        .priv_o(priv_o), .iaddr_o(iaddr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus of the current cycle
    int          s_nv;
    logic [31:0] s_addr [NRET];
    bit          s_comp [NRET];
    int          s_ity  [NRET];
    logic [31:0] s_cause, s_tval;
    logic [1:0]  s_priv;
    bit          s_flush;

    // reference model state: is a block open, where it started, halfwords so far
    bit          m_open;
    logic [31:0] m_start;
    int          m_cnt;
    bit          m_lsize;

    // expected packets
    bit          e_valid [NRET];
    int          e_iret  [NRET];
    bit          e_ls    [NRET];
    int          e_ity   [NRET];
    logic [31:0] e_cause [NRET];
    logic [31:0] e_tval  [NRET];
    logic [1:0]  e_priv  [NRET];
    logic [31:0] e_addr  [NRET];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        s_nv = 0;
        s_flush = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            s_addr[k] = '0; s_comp[k] = 1'b0; s_ity[k] = 0;
        end
    endtask

    task automatic set_lane(input int k, input logic [31:0] a, input bit c, input int t);
        s_addr[k] = a; s_comp[k] = c; s_ity[k] = t;
        if (s_nv < k + 1) s_nv = k + 1;
    endtask

    task automatic apply();
        for (int k = 0; k < NRET; k++) begin
            valid_i[k]                 = (k < s_nv);
            iaddr_i[k*XLEN +: XLEN]    = s_addr[k];
            compressed_i[k]            = s_comp[k];
            itype_i[k*TL +: TL]        = s_ity[k][TL-1:0];
        end
        cause_i = s_cause; tval_i = s_tval; priv_i = s_priv; flush_i = s_flush;
    endtask

    task automatic zero_exp();
        for (int k = 0; k < NRET; k++) begin
            e_valid[k] = 0; e_iret[k] = 0; e_ls[k] = 0; e_ity[k] = 0;
            e_cause[k] = '0; e_tval[k] = '0; e_priv[k] = '0; e_addr[k] = '0;
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_start = '0; m_cnt = 0; m_lsize = 0;
    endtask

    task automatic emit(input int k, input int t);
        e_valid[k] = 1; e_iret[k] = m_cnt; e_ls[k] = m_lsize; e_ity[k] = t;
        e_cause[k] = (t == 1 || t == 2) ? s_cause : 32'd0;
        e_tval[k]  = (t == 1 || t == 2) ? s_tval  : 32'd0;
        e_priv[k]  = s_priv; e_addr[k] = m_start;
        m_open = 0; m_cnt = 0;
    endtask

    // Block-level model: instructions join the open block; a block ends on any
    // non-sequential itype, on saturation, or at the last lane of a flushed cycle.
    task automatic model_step();
        zero_exp();
        for (int k = 0; k < s_nv; k++) begin
            if (!m_open) begin
                m_open = 1; m_start = s_addr[k]; m_cnt = 0;
            end
            m_cnt   += s_comp[k] ? 1 : 2;
            m_lsize  = !s_comp[k];
            if (s_ity[k] != 0 || m_cnt >= SATV || (s_flush && k == s_nv - 1))
                emit(k, s_ity[k]);
        end
        if (s_flush && s_nv == 0 && m_open) emit(0, 0);
    endtask

    task automatic check_all(input string ph);
        logic [NRET-1:0] ev;
        for (int k = 0; k < NRET; k++) ev[k] = e_valid[k];
        check({ph, "_valid"}, 64'(valid_o), 64'(ev));
        for (int k = 0; k < NRET; k++) begin
            check($sformatf("%s_iret%0d", ph, k),  64'(iretire_o[k*IL +: IL]), 64'(e_iret[k]));
            check($sformatf("%s_ls%0d", ph, k),    64'(ilastsize_o[k]), 64'(e_ls[k]));
            check($sformatf("%s_ity%0d", ph, k),   64'(itype_o[k*TL +: TL]), 64'(e_ity[k]));
            check($sformatf("%s_cause%0d", ph, k), 64'(cause_o[k*XLEN +: XLEN]), 64'(e_cause[k]));
            check($sformatf("%s_tval%0d", ph, k),  64'(tval_o[k*XLEN +: XLEN]), 64'(e_tval[k]));
            check($sformatf("%s_priv%0d", ph, k),  64'(priv_o[k*PL +: PL]), 64'(e_priv[k]));
            check($sformatf("%s_addr%0d", ph, k),  64'(iaddr_o[k*XLEN +: XLEN]), 64'(e_addr[k]));
        end
    endtask

    task automatic step(input string ph);
        apply();
        model_step();
        @(posedge clk_i);
        #1;
        check_all(ph);
    endtask

    task automatic randomize_stim();
        bit ctl;
        clear_stim();
        s_nv = $urandom_range(0, NRET);
        ctl = 0;
        for (int k = 0; k < s_nv; k++) begin
            s_addr[k] = $urandom() & 32'hFFFF_FFFE;
            s_comp[k] = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7) s_ity[k] = 0;
            else if (k == s_nv - 1)       s_ity[k] = $urandom_range(1, 6);
            else                          s_ity[k] = $urandom_range(3, 6);
            if (s_ity[k] >= 1 && s_ity[k] <= 3) ctl = 1;
        end
        s_cause = $urandom(); s_tval = $urandom();
        if (ctl) s_priv = $urandom_range(0, 3);
        s_flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        s_cause = '0; s_tval = '0; s_priv = '0;
        clear_stim();
        model_reset();

        // 1. reset held with random inputs
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            randomize_stim();
            apply();
            @(posedge clk_i);
            #1;
            zero_exp();
            check_all("rst_hold");
        end
        s_priv = 2'd0;
        clear_stim();
        apply();
        rst_i = 1'b0;
        model_reset();

        // reset while a block is open discards it
        clear_stim();
        set_lane(0, 32'h600, 1'b0, 0);
        step("open600");
        rst_i = 1'b1;
        #1;
        zero_exp();
        check_all("rst_async");
        clear_stim();
        apply();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        step("post_rst");

        // 2. single-cycle block
        clear_stim();
        set_lane(0, 32'h100, 1'b0, 0);
        set_lane(1, 32'h104, 1'b0, 5);
        step("blk1");
        check("t2_valid", 64'(valid_o), 64'h2);
        check("t2_addr1", 64'(iaddr_o[XLEN +: XLEN]), 64'h100);
        check("t2_iret1", 64'(iretire_o[IL +: IL]), 64'd4);
        check("t2_ls1",   64'(ilastsize_o[1]), 64'd1);
        check("t2_ity1",  64'(itype_o[TL +: TL]), 64'd5);

        // 3. cross-cycle block
        clear_stim();
        set_lane(0, 32'h200, 1'b1, 0);
        step("xA");
        check("t3_a_valid", 64'(valid_o), 64'h0);
        clear_stim();
        set_lane(0, 32'h202, 1'b0, 4);
        step("xB");
        check("t3_valid", 64'(valid_o), 64'h1);
        check("t3_addr0", 64'(iaddr_o[XLEN-1:0]), 64'h200);
        check("t3_iret0", 64'(iretire_o[IL-1:0]), 64'd3);
        check("t3_ls0",   64'(ilastsize_o[0]), 64'd1);
        check("t3_ity0",  64'(itype_o[TL-1:0]), 64'd4);

        // 4. saturation: 0x318 closes at 14 halfwords, 0x31C starts a new block
        for (int c = 0; c < 4; c++) begin
            clear_stim();
            set_lane(0, 32'h300 + 32'(8 * c), 1'b0, 0);
            set_lane(1, 32'h304 + 32'(8 * c), 1'b0, 0);
            step($sformatf("sat%0d", c));
        end
        check("t4_valid", 64'(valid_o), 64'h1);
        check("t4_addr0", 64'(iaddr_o[XLEN-1:0]), 64'h300);
        check("t4_iret0", 64'(iretire_o[IL-1:0]), 64'd14);
        check("t4_ity0",  64'(itype_o[TL-1:0]), 64'd0);
        clear_stim();
        set_lane(0, 32'h320, 1'b0, 5);
        step("sat_next");
        check("t4_new_addr", 64'(iaddr_o[XLEN-1:0]), 64'h31C);
        check("t4_new_iret", 64'(iretire_o[IL-1:0]), 64'd4);

        // 5. exception
        clear_stim();
        set_lane(0, 32'h400, 1'b0, 1);
        s_cause = 32'd2; s_tval = 32'hDEAD; s_priv = 2'd3;
        step("exc");
        check("t5_valid", 64'(valid_o), 64'h1);
        check("t5_ity0",  64'(itype_o[TL-1:0]), 64'd1);
        check("t5_cause", 64'(cause_o[XLEN-1:0]), 64'd2);
        check("t5_tval",  64'(tval_o[XLEN-1:0]), 64'hDEAD);
        check("t5_priv",  64'(priv_o[PL-1:0]), 64'd3);
        check("t5_iret",  64'(iretire_o[IL-1:0]), 64'd2);

        // 6. flush on an empty cycle, then a flush while idle
        clear_stim();
        set_lane(0, 32'h500, 1'b1, 0);
        step("fl_open");
        clear_stim();
        s_flush = 1'b1;
        step("fl1");
        check("t6_valid", 64'(valid_o), 64'h1);
        check("t6_addr0", 64'(iaddr_o[XLEN-1:0]), 64'h500);
        check("t6_iret0", 64'(iretire_o[IL-1:0]), 64'd1);
        check("t6_ls0",   64'(ilastsize_o[0]), 64'd0);
        check("t6_ity0",  64'(itype_o[TL-1:0]), 64'd0);
        step("fl2");
        check("t6_idle_valid", 64'(valid_o), 64'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomize_stim();
            step($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
